aes_inv_round_iter: RTL and testbench
=====================================

# aes_inv_round_iter

Iterative AES-128 decryption engine built around a parametrised inverse-round datapath. It accepts one ciphertext block together with the final (round-10) round key, and runs the inverse key schedule on the fly. It applies 10 inverse rounds, with the last round skipping InvMixColumns, and returns the plaintext over a valid/ready handshake. It generalises the single combinational last-round stage into a multi-round, unrollable, flow-controlled core sitting between the key/data loaders and the output buffer of the decryption path.

## Interface
- UNROLL, 1, inverse rounds evaluated per clock; legal values 1, 2, 5, 10 (must divide 10); illegal value is an elaboration error
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  cipher_in/key_in valid
- in_ready  out  1  engine can accept a block
- cipher_in  in  128  ciphertext, byte 0 in bits [127:120]
- key_in  in  128  round-10 key (last expanded key), same byte order
- out_valid  out  1  plain_out valid
- out_ready  in  1  downstream accepts plain_out
- plain_out  out  128  plaintext, same byte order
- busy  out  1  high in RUN state

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid: state_reg ← cipher_in ^ key_in, key_reg ← key_in, rnd ← 10, go RUN.
- RUN: each cycle applies UNROLL iterations. Iteration at round counter r (10 down to 1):
  - key step: k_{r-1} from k_r; p3=w3^w2, p2=w2^w1, p1=w1^w0, p0=w0^SubWord(RotWord(p3))^Rcon[r].
  - data: InvShiftRows → InvSubBytes → ^k_{r-1} → InvMixColumns only if r≠1.
  - r decrements per iteration. When rnd reaches 0 at the cycle edge: plain_out ← state, go DONE.
- DONE: out_valid=1, plain_out held stable until out_valid&&out_ready.
  - On handshake with in_valid=0 → IDLE.
  - On handshake with in_valid=1 → accept the new block the same cycle (in_ready = out_ready in DONE) and go RUN.
- in_ready=0 throughout RUN; in_valid there is ignored and does not stall anything.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, in the top byte of the word.
- All GF(2^8) arithmetic uses polynomial 0x11b. InvMixColumns coefficients are 0e,0b,0d,09.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, plain_out=0, rnd=0, state_reg/key_reg=0.
- Reset asserted mid-RUN or mid-DONE:
  - the block in flight is discarded immediately (asynchronous);
  - out_valid drops without a handshake;
  - after release the engine is in IDLE.
- Latency: out_valid rises 10/UNROLL clock edges after the accepting edge (UNROLL=1: 10, 2: 5, 5: 2, 10: 1).
- Throughput: one block per 10/UNROLL+1 cycles with out_ready held high and in_valid continuously asserted (back-to-back reload in DONE).
- No combinational path from in_valid to out_valid, or from out_ready to plain_out.
- in_ready in DONE is combinational from out_ready. This is the only input-to-output combinational path.

## Structure
- Shared package aes_dec_pkg:
  - Rcon table;
  - NR=10;
  - FSM state encoding;
  - inverse S-box and forward S-box (the key step needs the forward S-box) as functions;
  - gmul helpers for 09/0b/0d/0e.
- Sub-module aes_inv_round_step: one combinational iteration (inputs state, k_r, r; outputs next state, k_{r-1}). Instantiated UNROLL times in a generate chain.
- Top holds the FSM, registers and handshake only.

## Test plan
- FIPS-197 App. B, UNROLL=1: cipher 3925841d02dc09fbdc118597196a0b32, key d014f9a8c9ee2589e13f0cc8b6630ca6 → plain_out 3243f6a8885a308d313198a2e0370734, out_valid exactly 10 cycles after accept.
- FIPS-197 C.1, UNROLL ∈ {2,5,10}: cipher 69c4e0d86a7b0430d8cdb78070b4c55a, key 13111d7fe3944a17f307a78b4d2b30c5 → plain_out 00112233445566778899aabbccddeeff, latency 5/2/1 cycles.
- Backpressure: hold out_ready=0 for 7 cycles in DONE.
  - plain_out stays stable and in_ready=0;
  - after out_ready=1 with in_valid=1, the second block (C.1 vector) is accepted the same edge;
  - its result is correct.
- in_valid pulsed with a garbage block during RUN → ignored; first result unchanged.
- rst_n asserted at RUN cycle 4 → out_valid=0, plain_out=0 immediately. After release, in_ready=1 and the next App. B block decrypts correctly.
- Random regression: 1000 blocks, random keys, random valid/ready stalls, compared against a software AES-128 model (expanded key 10 fed as key_in).

Source files
------------

// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES-128 decryption path: round constants, FSM encoding,
// S-boxes and GF(2^8) helpers (polynomial 0x11b).
package aes_dec_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            else      p = p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gmul09(input logic [7:0] a); return gmul(a, 8'h09); endfunction
    function automatic logic [7:0] gmul0b(input logic [7:0] a); return gmul(a, 8'h0b); endfunction
    function automatic logic [7:0] gmul0d(input logic [7:0] a); return gmul(a, 8'h0d); endfunction
    function automatic logic [7:0] gmul0e(input logic [7:0] a); return gmul(a, 8'h0e); endfunction

    // Multiplicative inverse as a^254 via an addition chain; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gmul(gmul(a, a), a);
        x7   = gmul(gmul(x3, x3), a);
        x15  = gmul(gmul(x7, x7), a);
        x31  = gmul(gmul(x15, x15), a);
        x63  = gmul(gmul(x31, x31), a);
        x127 = gmul(gmul(x63, x63), a);
        return gmul(x127, x127);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x};
        return d[15 - n -: 8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

endpackage

// File: rtl/aes_inv_round_step.sv
// One combinational inverse round: derives k_{r-1} from k_r and applies
// InvShiftRows, InvSubBytes, AddRoundKey(k_{r-1}) and, unless r==1, InvMixColumns.
module aes_inv_round_step
    import aes_dec_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] key_in,
    input  logic [3:0]   rnd,
    output logic [127:0] state_out,
    output logic [127:0] key_out
);

    logic [31:0]  p0_s, p1_s, p2_s, p3_s, rot_s;
    logic [127:0] ark_s, mix_s;
    logic [7:0]   a0_s, a1_s, a2_s, a3_s;

    // Inverse key schedule step
    always_comb begin
        p3_s  = key_in[31:0]  ^ key_in[63:32];
        p2_s  = key_in[63:32] ^ key_in[95:64];
        p1_s  = key_in[95:64] ^ key_in[127:96];
        rot_s = {p3_s[23:0], p3_s[31:24]};
        p0_s  = key_in[127:96]
              ^ {sbox(rot_s[31:24]) ^ rcon(rnd), sbox(rot_s[23:16]), sbox(rot_s[15:8]), sbox(rot_s[7:0])};
        key_out = {p0_s, p1_s, p2_s, p3_s};
    end

    // Byte i sits at row i%4, column i/4; row r rotates right by r on the inverse shift
    always_comb begin
        ark_s = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                ark_s[127 - 8*(4*c + row) -: 8] =
                    inv_sbox(state_in[127 - 8*(4*((c - row + 4) % 4) + row) -: 8])
                    ^ key_out[127 - 8*(4*c + row) -: 8];
            end
        end
    end

    // InvMixColumns, bypassed on the final round
    always_comb begin
        mix_s = 128'd0;
        a0_s  = 8'h00;
        a1_s  = 8'h00;
        a2_s  = 8'h00;
        a3_s  = 8'h00;
        for (int c = 0; c < 4; c++) begin
            a0_s = ark_s[127 - 32*c -: 8];
            a1_s = ark_s[119 - 32*c -: 8];
            a2_s = ark_s[111 - 32*c -: 8];
            a3_s = ark_s[103 - 32*c -: 8];
            mix_s[127 - 32*c -: 8] = gmul0e(a0_s) ^ gmul0b(a1_s) ^ gmul0d(a2_s) ^ gmul09(a3_s);
            mix_s[119 - 32*c -: 8] = gmul09(a0_s) ^ gmul0e(a1_s) ^ gmul0b(a2_s) ^ gmul0d(a3_s);
            mix_s[111 - 32*c -: 8] = gmul0d(a0_s) ^ gmul09(a1_s) ^ gmul0e(a2_s) ^ gmul0b(a3_s);
            mix_s[103 - 32*c -: 8] = gmul0b(a0_s) ^ gmul0d(a1_s) ^ gmul09(a2_s) ^ gmul0e(a3_s);
        end
        if (rnd != 4'd1) state_out = mix_s;
        else             state_out = ark_s;
    end

endmodule

// File: rtl/aes_inv_round_iter.sv
// Iterative AES-128 decryption core: UNROLL inverse rounds per clock, on-the-fly inverse
// key schedule from the round-10 key, valid/ready on both sides.
module aes_inv_round_iter
    import aes_dec_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] cipher_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plain_out,
    output logic         busy
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
        $error("aes_inv_round_iter: UNROLL must be 1, 2, 5 or 10");
    end

    fsm_state_t   fsm_r, fsm_n;
    logic [127:0] state_r, state_n, key_r, key_n, plain_n;
    logic [3:0]   rnd_r, rnd_n;
    logic         accept_s;

    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        logic [127:0] st_i, ky_i, st_o, ky_o;
        if (g == 0) begin : g_first
            assign st_i = state_r;
            assign ky_i = key_r;
        end else begin : g_next
            assign st_i = g_step[g-1].st_o;
            assign ky_i = g_step[g-1].ky_o;
        end
        aes_inv_round_step u_step (
            .state_in  (st_i),
            .key_in    (ky_i),
            .rnd       (rnd_r - 4'(g)),
            .state_out (st_o),
            .key_out   (ky_o)
        );
    end

    // Next-state and datapath load decisions; in DONE a new block rides on the output handshake
    always_comb begin
        fsm_n    = fsm_r;
        state_n  = state_r;
        key_n    = key_r;
        rnd_n    = rnd_r;
        plain_n  = plain_out;
        in_ready = 1'b0;
        case (fsm_r)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        accept_s = in_valid && in_ready;
        case (fsm_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_n = cipher_in ^ key_in;
                    key_n   = key_in;
                    rnd_n   = 4'(NR);
                    fsm_n   = ST_RUN;
                end else if (fsm_r == ST_DONE && out_ready) begin
                    fsm_n = ST_IDLE;
                end else begin
                    fsm_n = fsm_r;
                end
            end
            ST_RUN: begin
                state_n = g_step[UNROLL-1].st_o;
                key_n   = g_step[UNROLL-1].ky_o;
                rnd_n   = rnd_r - 4'(UNROLL);
                if (rnd_r == 4'(UNROLL)) begin
                    plain_n = g_step[UNROLL-1].st_o;
                    fsm_n   = ST_DONE;
                end else begin
                    fsm_n = ST_RUN;
                end
            end
            default: fsm_n = ST_IDLE;
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r     <= ST_IDLE;
            state_r   <= 128'd0;
            key_r     <= 128'd0;
            rnd_r     <= 4'd0;
            plain_out <= 128'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            fsm_r     <= fsm_n;
            state_r   <= state_n;
            key_r     <= key_n;
            rnd_r     <= rnd_n;
            plain_out <= plain_n;
            out_valid <= (fsm_n == ST_DONE);
            busy      <= (fsm_n == ST_RUN);
        end
    end

endmodule

// File: tb/tb_aes_inv_round_iter.sv
// Bench for aes_inv_round_iter: four instances (UNROLL 1/2/5/10) for latency vectors,
// instance 0 for scoreboard-checked corner cases and a random regression.
module tb_aes_inv_round_iter;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] k10;
        logic [127:0] pt;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic [3:0]   iv, ordy, irdy, ov, busy;
    logic [127:0] cin [4];
    logic [127:0] kin [4];
    logic [127:0] pout [4];

    logic [7:0]   sb [256];
    logic [7:0]   rc [11];
    vec_t         vec [4];
    logic [127:0] exp_q [$];
    int           n_cmp, n_bad;
    logic         sb_en, hold_v, done_flag;
    logic [127:0] hold_p;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        aes_inv_round_iter #(.UNROLL(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (irdy[g]),
            .cipher_in (cin[g]),
            .key_in    (kin[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .plain_out (pout[g]),
            .busy      (busy[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward AES-128 reference: encrypt pt under the master key, also return round key 10
    task automatic aes_enc(input logic [127:0] key, input logic [127:0] pt,
                           output logic [127:0] ct, output logic [127:0] k10);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  s [16];
        logic [7:0]  u [16];
        logic [7:0]  a0, a1, a2, a3;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]] ^ rc[i/4], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ key[127 - 8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) u[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c + row] = u[4*((c + row) % 4) + row];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127 - 8*i -: 8] = s[i];
        k10 = {w[40], w[41], w[42], w[43]};
    endtask

    // Drive a block on instance 0 (caller at posedge+1); push its expectation when accepted
    task automatic send(input logic [127:0] c, input logic [127:0] k, input logic [127:0] p);
        int n;
        n = 0;
        iv[0] = 1'b1; cin[0] = c; kin[0] = k;
        forever begin
            @(negedge clk);
            if (irdy[0]) break;
            n++;
            if (n > 300) begin
                chk("send_timeout", 128'(irdy[0]), 128'd1);
                break;
            end
        end
        if (irdy[0]) exp_q.push_back(p);
        @(posedge clk); #1;
        iv[0] = 1'b0;
    endtask

    task automatic wait_ov(input int limit);
        int n;
        n = 0;
        while (!ov[0] && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ov[0]) chk("wait_ov_timeout", 128'(ov[0]), 128'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        logic [127:0] mk, pt, ct, k10;
        int lat;
        n_cmp = 0; n_bad = 0;
        sb_en = 1'b0; hold_v = 1'b0; hold_p = 128'd0; done_flag = 1'b0;
        rst_n = 1'b0; iv = 4'd0; ordy = 4'd0;
        for (int d = 0; d < 4; d++) begin cin[d] = 128'd0; kin[d] = 128'd0; end

        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv, b;
            inv = 8'h00;
            for (int x = 1; x < 256; x++) if (gm(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[a] = b;
        end
        rc = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

        vec[0] = '{128'h3925841d02dc09fbdc118597196a0b32, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                   128'h3243f6a8885a308d313198a2e0370734};
        vec[1] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5,
                   128'h00112233445566778899aabbccddeeff};
        aes_enc(128'd0, {128{1'b1}}, ct, k10);
        vec[2] = '{ct, k10, {128{1'b1}}};
        aes_enc({128{1'b1}}, 128'd0, ct, k10);
        vec[3] = '{ct, k10, 128'd0};

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            chk("rst_in_ready", 128'(irdy[d]), 128'd1);
            chk("rst_out_valid", 128'(ov[d]), 128'd0);
            chk("rst_busy", 128'(busy[d]), 128'd0);
            chk("rst_plain", pout[d], 128'd0);
        end
        rst_n = 1'b1;

        // Table: every vector on every unroll factor, checking latency and plaintext
        for (int d = 0; d < 4; d++) begin
            for (int v = 0; v < 4; v++) begin
                @(posedge clk); #1;
                cin[d] = vec[v].ct; kin[d] = vec[v].k10; iv[d] = 1'b1; ordy[d] = 1'b1;
                @(negedge clk);
                chk("tbl_in_ready", 128'(irdy[d]), 128'd1);
                @(posedge clk); #1;
                iv[d] = 1'b0;
                lat = 0;
                while (!ov[d] && lat < 40) begin
                    @(posedge clk); #1;
                    lat++;
                end
                chk("tbl_latency", 128'(lat), 128'(d == 0 ? 10 : d == 1 ? 5 : d == 2 ? 2 : 1));
                chk("tbl_plain", pout[d], vec[v].pt);
            end
        end
        repeat (2) begin @(posedge clk); #1; end

        sb_en = 1'b1;
        fork
            forever begin
                @(negedge clk);
                if (sb_en && rst_n) begin
                    if (ov[0]) begin
                        if (hold_v) chk("hold_stable", pout[0], hold_p);
                        if (ordy[0]) begin
                            if (exp_q.size() == 0) begin
                                n_cmp++; n_bad++;
                                $display("FAIL unexpected_out: got %h expected no output", pout[0]);
                            end else begin
                                chk("sb_plain", pout[0], exp_q.pop_front());
                            end
                            hold_v = 1'b0;
                        end else begin
                            hold_v = 1'b1;
                            hold_p = pout[0];
                        end
                    end else begin
                        hold_v = 1'b0;
                    end
                end else begin
                    hold_v = 1'b0;
                end
            end
        join_none

        // Backpressure in DONE, then back-to-back acceptance on the handshake edge
        ordy[0] = 1'b0;
        send(vec[0].ct, vec[0].k10, vec[0].pt);
        wait_ov(40);
        repeat (7) begin
            @(negedge clk);
            chk("bp_in_ready", 128'(irdy[0]), 128'd0);
            chk("bp_out_valid", 128'(ov[0]), 128'd1);
        end
        @(posedge clk); #1;
        ordy[0] = 1'b1;
        send(vec[1].ct, vec[1].k10, vec[1].pt);
        chk("b2b_busy", 128'(busy[0]), 128'd1);
        chk("b2b_out_valid", 128'(ov[0]), 128'd0);
        drain();

        // Garbage in_valid pulse during RUN is ignored
        send(vec[0].ct, vec[0].k10, vec[0].pt);
        @(posedge clk); #1;
        iv[0] = 1'b1; cin[0] = {4{$urandom}}; kin[0] = {4{$urandom}};
        @(negedge clk);
        chk("run_in_ready", 128'(irdy[0]), 128'd0);
        chk("run_busy", 128'(busy[0]), 128'd1);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        drain();

        // Reset in the middle of RUN
        send(vec[0].ct, vec[0].k10, vec[0].pt);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstrun_out_valid", 128'(ov[0]), 128'd0);
        chk("rstrun_plain", pout[0], 128'd0);
        chk("rstrun_busy", 128'(busy[0]), 128'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstrun_in_ready", 128'(irdy[0]), 128'd1);
        send(vec[0].ct, vec[0].k10, vec[0].pt);
        drain();

        // Reset while a result waits in DONE
        ordy[0] = 1'b0;
        send(vec[1].ct, vec[1].k10, vec[1].pt);
        wait_ov(40);
        rst_n = 1'b0;
        #1;
        chk("rstdone_out_valid", 128'(ov[0]), 128'd0);
        chk("rstdone_plain", pout[0], 128'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ordy[0] = 1'b1;
        send(vec[1].ct, vec[1].k10, vec[1].pt);
        drain();

        // Random regression with input gaps and output stalls
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    mk = {$urandom, $urandom, $urandom, $urandom};
                    pt = {$urandom, $urandom, $urandom, $urandom};
                    aes_enc(mk, pt, ct, k10);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send(ct, k10, pt);
                end
                done_flag = 1'b1;
            end
            begin
                while (!done_flag) begin
                    @(posedge clk); #1;
                    ordy[0] = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ordy[0] = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
